// File: rtl/arb_req_mux.sv
// Requester-side front end for a round-robin arbiter: one holding slot per client,
// granted payload forwarded through a registered valid/ready stage.
// Optional grant protocol checker enabled by defining ARB_REQ_MUX_ERRCHK_EN.
module arb_req_mux #(
  parameter int num_req = 4,
  parameter int DATA_W = 8,
  localparam int SRC_W = $clog2(num_req)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [num_req-1:0]        in_valid,
  input  logic [num_req*DATA_W-1:0] in_data,
  output logic [num_req-1:0]        in_ready,
  output logic [num_req-1:0]        arb_req,
  input  logic [num_req-1:0]        arb_gnt,
  output logic                      arb_adv,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic                      gnt_err
);

  logic [num_req-1:0] slot_v_reg;
  logic [DATA_W-1:0]  slot_d_reg [num_req];
  logic               out_valid_reg;
  logic [DATA_W-1:0]  out_data_reg;
  logic [SRC_W-1:0]   out_src_reg;

  logic               ofree;
  logic               take;
  logic [num_req-1:0] gv;
  logic [num_req-1:0] win_oh;
  logic [SRC_W-1:0]   win_idx;

  // Lowest granted valid slot wins, so a multi-hot grant still issues only once.
  always_comb begin
    ofree   = ~out_valid_reg | out_ready;
    gv      = arb_gnt & slot_v_reg;
    win_oh  = '0;
    win_idx = '0;
    for (int i = num_req - 1; i >= 0; i--) begin
      if (gv[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_idx   = i[SRC_W-1:0];
      end
    end
    take = ofree & (|gv) & ~rst;
  end

  assign in_ready = rst ? '0 : (~slot_v_reg | (take ? win_oh : '0));
  assign arb_req  = slot_v_reg;
  assign arb_adv  = take;

  genvar gi;
  generate
    for (gi = 0; gi < num_req; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_v_reg[gi] <= 1'b0;
          slot_d_reg[gi] <= '0;
        end else if (in_valid[gi] & in_ready[gi]) begin
          slot_v_reg[gi] <= 1'b1;
          slot_d_reg[gi] <= in_data[gi*DATA_W +: DATA_W];
        end else if (take & win_oh[gi]) begin
          slot_v_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
    end else if (take) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= slot_d_reg[win_idx];
      out_src_reg   <= win_idx;
    end else if (ofree) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

`ifdef ARB_REQ_MUX_ERRCHK_EN
  localparam logic [num_req-1:0] ONE = num_req'(1);
  logic gnt_err_reg;
  logic multi_hot;
  logic stray;

  // An all-zero grant is an idle arbiter, not an error; only multi-hot or stray bits flag.
  assign multi_hot = |(arb_gnt & (arb_gnt - ONE));
  assign stray     = (|slot_v_reg) & (|(arb_gnt & ~slot_v_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_err_reg <= 1'b0;
    end else if (multi_hot | stray) begin
      gnt_err_reg <= 1'b1;
    end
  end

  assign gnt_err = gnt_err_reg;
`else
  assign gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_mux.sv
// Self-checking bench for arb_req_mux: behavioural round-robin arbiter, reference slot
// model and an output scoreboard queue filled on each predicted grant consumption.
module tb_arb_req_mux;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    arb_gnt;
  logic            arb_adv;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic            gnt_err;

  arb_req_mux #(.num_req(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_adv(arb_adv), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready), .gnt_err(gnt_err)
  );

  always #5 clk = ~clk;

  int vectors_applied = 0;
  int miscompares = 0;

  // Arbiter stand-in: rotating priority from ptr, or a forced grant pattern.
  logic         force_en = 1'b0;
  logic [N-1:0] force_val = '0;
  int           ptr = 0;

  always_comb begin
    arb_gnt = '0;
    if (force_en) arb_gnt = force_val;
    else begin
      for (int k = 0; k < N; k++) begin
        if (arb_req[(ptr + k) % N] && arb_gnt == '0) arb_gnt[(ptr + k) % N] = 1'b1;
      end
    end
  end

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
  } item_t;

  item_t        sb[$];
  logic [N-1:0] m_v = '0;
  logic [DW-1:0] m_d [N];
  logic         m_ov = 1'b0;
  logic         m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] d);
    in_data[k*DW +: DW] = d;
  endtask

  // One clock: compare at negedge, then advance the model just after posedge.
  task automatic step();
    logic [N-1:0] gv, one_w, exp_rdy, s_valid, s_gnt;
    logic [N*DW-1:0] s_data;
    logic ofree, take, s_rst, s_ordy, multi, stray;
    int w;
    @(negedge clk);
    s_rst = rst; s_ordy = out_ready; s_valid = in_valid; s_data = in_data; s_gnt = arb_gnt;
    ofree = !m_ov || s_ordy;
    gv = s_gnt & m_v;
    w = -1;
    for (int k = 0; k < N; k++) if (gv[k] && w < 0) w = k;
    take = ofree && (w >= 0) && !s_rst;
    one_w = '0;
    if (take) one_w[w] = 1'b1;
    exp_rdy = s_rst ? '0 : (~m_v | one_w);
    check("arb_req", 32'(arb_req), 32'(m_v));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("arb_adv", 32'(arb_adv), 32'(take));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("gnt_err", 32'(gnt_err), 32'(m_err));
    if (m_ov) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        check("out_data", 32'(out_data), 32'(sb[0].data));
        check("out_src", 32'(out_src), 32'(sb[0].src));
      end
    end
    multi = |(s_gnt & (s_gnt - N'(1)));
    stray = (|m_v) && (|(s_gnt & ~m_v));
    @(posedge clk);
    #1;
    if (s_rst) begin
      m_v = '0; m_ov = 1'b0; m_err = 1'b0; ptr = 0;
      for (int k = 0; k < N; k++) m_d[k] = '0;
      sb.delete();
    end else begin
      if (m_ov && s_ordy && sb.size() > 0) begin
        $display("xfer src=%0d data=%02h", sb[0].src, sb[0].data);
        void'(sb.pop_front());
      end
      if (take) begin
        sb.push_back(item_t'{src: SW'(w), data: m_d[w]});
        m_ov = 1'b1;
        m_v[w] = 1'b0;
        ptr = (w + 1) % N;
      end else if (ofree) m_ov = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (s_valid[k] && exp_rdy[k]) begin
          m_v[k] = 1'b1;
          m_d[k] = s_data[k*DW +: DW];
        end
      end
`ifdef ARB_REQ_MUX_ERRCHK_EN
      if (multi || stray) m_err = 1'b1;
`endif
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '1; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < N; k++) m_d[k] = '0;
    @(posedge clk); #1;
    // Reset held with all clients requesting
    repeat (2) step();
    // Single push from client 2
    rst = 1'b0; in_valid = '0;
    step();
    in_valid = 4'b0100; set_data(2, 8'hA5);
    step();
    in_valid = '0;
    repeat (3) step();
    // All clients at once, arbiter pointer restarted at 0
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = '1;
    for (int k = 0; k < N; k++) set_data(k, 8'(8'h10 + k));
    step();
    in_valid = '0;
    repeat (6) step();
    // Backpressure with refill attempts
    in_valid = '1;
    for (int k = 0; k < N; k++) set_data(k, 8'(8'h20 + k));
    step();
    in_valid = '0; step();
    out_ready = 1'b0; in_valid = '1;
    for (int k = 0; k < N; k++) set_data(k, 8'(8'h30 + k));
    repeat (5) step();
    out_ready = 1'b1; in_valid = '0;
    repeat (8) step();
    // Client 1 streaming every cycle
    for (int i = 0; i < 10; i++) begin
      in_valid = 4'b0010; set_data(1, 8'(8'h40 + i));
      step();
    end
    in_valid = '0;
    repeat (4) step();
    // Multi-hot grant
    force_en = 1'b1; force_val = '0;
    in_valid = 4'b0011; set_data(0, 8'h50); set_data(1, 8'h51);
    step();
    in_valid = '0; force_val = 4'b0011;
    step();
    force_en = 1'b0;
    repeat (4) step();
    // Randomised traffic with a mid-stream reset
    for (int i = 0; i < 120; i++) begin
      in_valid = N'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) set_data(k, 8'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 9) < 7);
      rst = (i == 60);
      step();
    end
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
    repeat (8) step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
